// File: rtl/gpio_input_conditioner_pkg.sv
// Shared types and default constants for the GPIO input conditioner.
package gpio_pkg;

  typedef enum logic {
    DB_STABLE,
    DB_CHANGING
  } db_state_t;

  localparam int GPIO_SYNC_STAGES     = 2;
  localparam int GPIO_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pads in, clean levels/events out.
interface gpio_input_conditioner_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] stable_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] edge_sticky;

  modport master (
    output pad_in,
    output edge_clear,
    input  stable_out,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_sticky
  );

  modport slave (
    input  pad_in,
    input  edge_clear,
    output stable_out,
    output rise_pulse,
    output fall_pulse,
    output edge_sticky
  );

endinterface

// File: rtl/gpio_input_conditioner_debounce.sv
// One-bit synchronizer, debounce FSM and registered rise/fall pulses.
//   state       | meaning
//   DB_STABLE   | synced input equals accepted level, counter idle at 0
//   DB_CHANGING | synced input differs, counting consecutive differing cycles
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_next_o,
  output logic fall_next_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  db_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync;
  logic                   differ;
  logic                   commit;
  logic                   rise_d;
  logic                   fall_d;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign differ = (sync != stable_q);
  assign commit = (state_q == DB_CHANGING) && differ && (cnt_q == CNT_LAST);
  assign rise_d = commit & sync;
  assign fall_d = commit & ~sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= DB_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      rise_q <= rise_d;
      fall_q <= fall_d;
      case (state_q)
        DB_STABLE: begin
          if (differ) begin
            state_q <= DB_CHANGING;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        DB_CHANGING: begin
          // Any single matching sample rejects the pending change outright.
          if (!differ) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync;
            state_q  <= DB_STABLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= DB_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stable_o    = stable_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign rise_next_o = rise_d;
  assign fall_next_o = fall_d;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Per-bit debounce array plus the write-1-to-clear sticky edge flags.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input logic                     clk,
  input logic                     rst,
  gpio_input_conditioner_if.slave bus
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] sticky_q;
  logic [WIDTH-1:0] sticky_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .pad_i      (bus.pad_in[i]),
      .stable_o   (stable[i]),
      .rise_o     (rise_q[i]),
      .fall_o     (fall_q[i]),
      .rise_next_o(rise_d[i]),
      .fall_next_o(fall_d[i])
    );
  end

  // Set is OR'd in after the clear so a commit coinciding with a clear survives.
  assign sticky_d = (sticky_q & ~bus.edge_clear) | rise_d | fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.stable_out  = stable;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.edge_sticky = sticky_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized bounce against a reference model.
module tb_gpio_input_conditioner;
  import gpio_pkg::*;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_input_conditioner_if #(.WIDTH(W)) bus ();

  gpio_input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_stable;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] m_sticky;
  int           m_run [W];
  logic [W-1:0] m_pipe [$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_sticky = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_pipe.delete();
    for (int i = 0; i < SS; i++) m_pipe.push_back('0);
  endfunction

  // Synced sample = pad seen SS edges ago; accept after DB consecutive differing samples.
  function automatic void model_step();
    logic [W-1:0] s;
    if (rst) begin
      model_reset();
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(bus.pad_in);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sticky = (m_sticky & ~bus.edge_clear) | m_rise | m_fall;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("stable", bus.stable_out, m_stable);
    check_eq("rise", bus.rise_pulse, m_rise);
    check_eq("fall", bus.fall_pulse, m_fall);
    check_eq("sticky", bus.edge_sticky, m_sticky);
    if ((bus.rise_pulse & bus.fall_pulse) != '0)
      check_eq("rise_and_fall", bus.rise_pulse & bus.fall_pulse, '0);
  endtask

  initial begin
    logic [W-1:0] zero_w;
    zero_w         = '0;
    rst            = 1'b1;
    bus.pad_in     = '0;
    bus.edge_clear = '0;
    model_reset();

    repeat (2) tick();
    check_eq("reset_out", bus.stable_out | bus.rise_pulse | bus.fall_pulse | bus.edge_sticky, zero_w);
    rst = 1'b0;

    // Glitch on bit 3: three synced high samples fall short of acceptance.
    bus.pad_in = 32'h8;
    repeat (3) tick();
    bus.pad_in = '0;
    repeat (8) begin
      tick();
      check_eq("glitch_out", bus.stable_out | bus.rise_pulse | bus.fall_pulse | bus.edge_sticky, zero_w);
    end

    // Rise on bit 0: visible after exactly six edges.
    bus.pad_in = 32'h1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        check_eq("rise_early_stable", bus.stable_out, zero_w);
        check_eq("rise_early_pulse", bus.rise_pulse, zero_w);
      end else begin
        check_eq("rise_stable", bus.stable_out, 32'h1);
        check_eq("rise_pulse", bus.rise_pulse, 32'h1);
        check_eq("rise_sticky", bus.edge_sticky, 32'h1);
      end
    end
    tick();
    check_eq("rise_one_cycle", bus.rise_pulse, zero_w);
    check_eq("rise_held", bus.stable_out, 32'h1);

    // All ones, then simultaneous fall on every bit.
    bus.pad_in = '1;
    repeat (8) tick();
    check_eq("all_high", bus.stable_out, 32'hFFFF_FFFF);
    bus.pad_in = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("fall_no_rise", bus.rise_pulse, zero_w);
      if (k == 6) begin
        check_eq("fall_pulse_all", bus.fall_pulse, 32'hFFFF_FFFF);
        check_eq("fall_stable", bus.stable_out, zero_w);
      end
    end
    tick();
    check_eq("fall_one_cycle", bus.fall_pulse, zero_w);

    // Clear alone, then clear colliding with a commit on bit 0.
    bus.edge_clear = 32'h1;
    tick();
    bus.edge_clear = '0;
    check_eq("clear_alone", bus.edge_sticky, 32'hFFFF_FFFE);
    bus.pad_in = 32'h1;
    repeat (5) tick();
    bus.edge_clear = 32'h1;
    tick();
    check_eq("collide_rise", bus.rise_pulse, 32'h1);
    check_eq("collide_sticky", bus.edge_sticky, 32'hFFFF_FFFF);
    bus.edge_clear = '0;
    tick();
    check_eq("collide_after", bus.edge_sticky, 32'hFFFF_FFFF);

    // Reset in the middle of a count on bit 5.
    bus.edge_clear = '1;
    tick();
    bus.edge_clear = '0;
    bus.pad_in = 32'h21;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      check_eq("rst_mid_out", bus.stable_out | bus.rise_pulse | bus.fall_pulse | bus.edge_sticky, zero_w);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("rst_bit5", W'(bus.stable_out[5]), (k == 6) ? W'(1) : zero_w);
    end

    // Randomized bounce with occasional clears and resets.
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        logic [W-1:0] flips;
        flips = $urandom & $urandom & $urandom;
        if (seg[0]) flips = flips & $urandom;
        bus.pad_in     = bus.pad_in ^ flips;
        bus.edge_clear = $urandom & $urandom & $urandom & $urandom;
        rst            = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
